float_byte_serializer: RTL

//   Buffers 32-bit IEEE-754 pixel words from the int16-to-float converter stage and

---
 rtl/float_byte_serializer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/float_byte_serializer.sv
// Float word to little-endian byte stream serializer.
// Word FIFO in front of a 4-byte output shift stage with frame tracking.
module float_byte_serializer #(
   parameter int DEPTH            = 4,
   parameter int PIXELS_PER_FRAME = 768,
   parameter int CNT_W            = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      in_float,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       out_byte,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic [CNT_W-1:0] pixel_index,
   output logic             overflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIXELS_PER_FRAME - 1);

   typedef enum logic {
      S_IDLE,
      S_SEND
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [31:0]      r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic [31:0]      r_word;
   logic [1:0]       r_byte_idx;
   logic [CNT_W-1:0] r_pix;
   logic             r_ovf;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_xfer;
   logic w_word_done;

   assign w_full      = (r_count == FULL_CNT);
   assign w_empty     = (r_count == '0);
   assign in_ready    = ~reset & ~w_full;
   assign w_push      = in_valid & in_ready;
   assign w_xfer      = (r_state == S_SEND) & out_ready;
   assign w_word_done = w_xfer & (r_byte_idx == 2'd3);
   assign w_pop       = ~w_empty & ((r_state == S_IDLE) | w_word_done);

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // FSM next state: load a word when idle, return idle when drained
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (!w_empty) w_next = S_SEND;
         S_SEND: if (w_word_done && w_empty) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // FSM outputs: byte lane select and frame-end flag
   always_comb begin
      out_valid = (r_state == S_SEND);
      out_byte  = 8'h00;
      if (out_valid) out_byte = r_word[{r_byte_idx, 3'b000} +: 8];
      out_last  = out_valid & (r_byte_idx == 2'd3) & (r_pix == LAST_PIX);
   end

   // FIFO storage, no reset needed on payload
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= in_float;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Output word register and byte position
   always_ff @(posedge clk) begin
      if (reset) begin
         r_word     <= '0;
         r_byte_idx <= '0;
      end else if (w_pop) begin
         r_word     <= r_mem[r_rptr];
         r_byte_idx <= '0;
      end else if (w_xfer) begin
         r_byte_idx <= r_byte_idx + 1'b1;
      end
   end

   // Pixel position within the frame
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pix <= '0;
      end else if (w_word_done) begin
         if (r_pix == LAST_PIX) r_pix <= '0;
         else                   r_pix <= r_pix + 1'b1;
      end
   end

   // Sticky flag for words dropped against a full FIFO
   always_ff @(posedge clk) begin
      if (reset)                  r_ovf <= 1'b0;
      else if (in_valid && !in_ready) r_ovf <= 1'b1;
   end

   assign pixel_index = r_pix;
   assign overflow    = r_ovf;

endmodule
